// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined 4-bit-group carry-lookahead adder/subtractor with valid/ready flow control
module pipelined_cla_adder #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NGROUPS = WIDTH / 4;
  localparam int L       = NGROUPS / GROUPS_PER_STAGE;

  // Stage registers: operands travel forward with the partial sum so the
  // unresolved upper groups are still available to later stages.
  logic [WIDTH-1:0] a_q   [L];
  logic [WIDTH-1:0] b_q   [L];
  logic [WIDTH-1:0] sum_q [L];
  logic [L-1:0]     v_q;
  logic [L-1:0]     c_q;
  logic             ovf_q;
  logic             zero_q;

  // Per-stage inputs (stage 0 reads the ports, stage k reads stage k-1).
  logic [WIDTH-1:0] src_a   [L];
  logic [WIDTH-1:0] src_b   [L];
  logic [WIDTH-1:0] src_sum [L];
  logic [WIDTH-1:0] nxt_sum [L];
  logic [L-1:0]     src_v;
  logic [L-1:0]     src_c;
  logic [L-1:0]     nxt_c;
  logic [L-1:0]     rdy;
  logic             msb_c;

  // Ready chain: a stage can load if it or any stage downstream has a hole,
  // or the consumer is taking the head beat this cycle.
  always_comb begin : ready_chain
    logic r;
    r = out_ready;
    for (int k = L - 1; k >= 0; k--) begin
      r      = r || !v_q[k];
      rdy[k] = r;
    end
  end

  assign in_ready = Reset_n && rdy[0];

  // Stage sources: subtraction is folded into stage 0 as ~B with carry-in 1.
  always_comb begin
    src_a[0]   = A;
    src_b[0]   = sub ? ~B : B;
    src_sum[0] = '0;
    src_c[0]   = sub | cin;
    src_v[0]   = in_valid && in_ready;
    for (int k = 1; k < L; k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_c[k]   = c_q[k-1];
      src_v[k]   = v_q[k-1];
    end
  end

  // Lookahead logic: each stage resolves its own slice of 4-bit groups,
  // rippling the group carry-out between groups inside the stage.
  always_comb begin : lookahead
    logic [3:0] p;
    logic [3:0] g;
    logic       c0, c1, c2, c3, c4;
    int         base;
    msb_c = 1'b0;
    for (int k = 0; k < L; k++) begin
      nxt_sum[k] = src_sum[k];
      c0         = src_c[k];
      for (int j = 0; j < GROUPS_PER_STAGE; j++) begin
        base = (k * GROUPS_PER_STAGE + j) * 4;
        p    = src_a[k][base +: 4] ^ src_b[k][base +: 4];
        g    = src_a[k][base +: 4] & src_b[k][base +: 4];
        c1   = g[0] | (p[0] & c0);
        c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        nxt_sum[k][base +: 4] = p ^ {c3, c2, c1, c0};
        if (base + 4 == WIDTH) begin
          msb_c = c3;
        end
        c0 = c4;
      end
      nxt_c[k] = c0;
    end
  end

  // Pipeline advance: a stage loads only when ready, keeps data while stalled,
  // and skips the data load on bubbles so held results never toggle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < L; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      v_q    <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      for (int k = 0; k < L; k++) begin
        if (rdy[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            sum_q[k] <= nxt_sum[k];
            c_q[k]   <= nxt_c[k];
          end
        end
      end
      if (rdy[L-1] && src_v[L-1]) begin
        ovf_q  <= msb_c ^ nxt_c[L-1];
        zero_q <= ~|nxt_sum[L-1];
      end
    end
  end

  assign out_valid = v_q[L-1];
  assign S         = sum_q[L-1];
  assign cout      = c_q[L-1];
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
